// File: rtl/uart_mem_pkg.sv
// Shared constants for the UART-to-RAM command sequencer: protocol bytes and FSM states.
package uart_mem_pkg;

  localparam logic [7:0] CMD_W     = 8'h57;
  localparam logic [7:0] CMD_R     = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_BAD   = 8'h3F;
  localparam logic [7:0] RSP_RANGE = 8'h21;

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO,
    MEM_WR, MEM_RD, RD_WAIT, TX_LOAD, TX_WAIT
  } state_t;

endpackage

// File: rtl/uart_gap_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT_CLKS and holds expired until cleared.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 868*20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CLKS + 1);

  logic [CW-1:0] cnt;

  assign expired = (cnt == CW'(TIMEOUT_CLKS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clr)           cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_mem_ctrl.sv
// Parses framed R/W commands from the UART RX stream, accesses the word RAM and
// queues one- or two-byte replies onto the UART TX under its busy/done handshake.
module uart_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int ADDR_W       = 15,
  parameter int DEPTH        = 32000,
  parameter int TIMEOUT_CLKS = 868*20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rx_dv,
  input  logic [7:0]        i_rx_byte,
  output logic              o_tx_dv,
  output logic [7:0]        o_tx_byte,
  input  logic              i_tx_active,
  input  logic              i_tx_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [15:0]       o_mem_wdata,
  output logic              o_mem_re,
  input  logic [15:0]       i_mem_rdata,
  output logic [ADDR_W-1:0] o_last_addr,
  output logic              o_drop
);

  state_t state, next;

  logic              is_wr, range_err, pend, expired, gather, in_range;
  logic [7:0]        ah, tx_next;
  logic [15:0]       full_addr;

  assign full_addr = {ah, i_rx_byte};
  // Any set bit above ADDR_W or a value past DEPTH is out of range.
  assign in_range  = ((full_addr >> ADDR_W) == '0) && ({16'd0, full_addr} < 32'(DEPTH));
  assign gather    = state inside {ADDR_HI, ADDR_LO, DATA_HI, DATA_LO};

  uart_gap_timer #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_gap (
    .clk     (clk),
    .rst     (rst),
    .clr     (i_rx_dv || !gather),
    .en      (gather),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  // An arriving byte always takes priority over gap-timer expiry.
  always_comb begin
    next     = state;
    o_mem_we = 1'b0;
    o_mem_re = 1'b0;
    o_tx_dv  = 1'b0;
    o_drop   = i_rx_dv && (state inside {MEM_WR, MEM_RD, RD_WAIT, TX_LOAD, TX_WAIT});
    case (state)
      IDLE:    if (i_rx_dv) next = (i_rx_byte == CMD_W || i_rx_byte == CMD_R) ? ADDR_HI : TX_LOAD;
      ADDR_HI: if (i_rx_dv) next = ADDR_LO; else if (expired) next = IDLE;
      ADDR_LO: begin
        if (i_rx_dv) begin
          if (is_wr)         next = DATA_HI;
          else if (in_range) next = MEM_RD;
          else               next = TX_LOAD;
        end else if (expired) next = IDLE;
      end
      DATA_HI: if (i_rx_dv) next = DATA_LO; else if (expired) next = IDLE;
      DATA_LO: if (i_rx_dv) next = range_err ? TX_LOAD : MEM_WR; else if (expired) next = IDLE;
      MEM_WR:  begin o_mem_we = 1'b1; next = TX_LOAD; end
      MEM_RD:  begin o_mem_re = 1'b1; next = RD_WAIT; end
      RD_WAIT: next = TX_LOAD;
      TX_LOAD: if (!i_tx_active) begin o_tx_dv = 1'b1; next = TX_WAIT; end
      TX_WAIT: if (i_tx_done) next = pend ? TX_LOAD : IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_wr       <= 1'b0;
      range_err   <= 1'b0;
      pend        <= 1'b0;
      ah          <= '0;
      tx_next     <= '0;
      o_tx_byte   <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_last_addr <= '0;
    end else begin
      case (state)
        IDLE: if (i_rx_dv) begin
          is_wr     <= (i_rx_byte == CMD_W);
          pend      <= 1'b0;
          if (i_rx_byte != CMD_W && i_rx_byte != CMD_R) o_tx_byte <= RSP_BAD;
        end
        ADDR_HI: if (i_rx_dv) ah <= i_rx_byte;
        ADDR_LO: if (i_rx_dv) begin
          o_mem_addr <= full_addr[ADDR_W-1:0];
          range_err  <= !in_range;
          if (!is_wr && !in_range) o_tx_byte <= RSP_RANGE;
        end
        DATA_HI: if (i_rx_dv) o_mem_wdata[15:8] <= i_rx_byte;
        DATA_LO: if (i_rx_dv) begin
          o_mem_wdata[7:0] <= i_rx_byte;
          if (range_err) o_tx_byte <= RSP_RANGE;
        end
        MEM_WR: begin
          o_last_addr <= o_mem_addr;
          o_tx_byte   <= RSP_OK;
        end
        MEM_RD:  o_last_addr <= o_mem_addr;
        RD_WAIT: begin
          o_tx_byte <= i_mem_rdata[15:8];
          tx_next   <= i_mem_rdata[7:0];
          pend      <= 1'b1;
        end
        TX_WAIT: if (i_tx_done && pend) begin
          o_tx_byte <= tx_next;
          pend      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Directed plus randomized command traffic against a RAM/TX environment and a
// command-level reference model of the sequencer.
module tb_uart_mem_ctrl;

  localparam int ADDR_W       = 15;
  localparam int DEPTH        = 32000;
  localparam int TIMEOUT_CLKS = 868*20;
  localparam int TX_CLKS      = 12;

  logic              clk = 1'b0, rst = 1'b1;
  logic              rx_dv = 1'b0;
  logic [7:0]        rx_byte = 8'h00;
  logic              tx_dv;
  logic [7:0]        tx_byte;
  logic              tx_active = 1'b0, tx_done = 1'b0;
  logic [ADDR_W-1:0] mem_addr, last_addr;
  logic              mem_we, mem_re, drop;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata = 16'h0;

  always #5 clk = ~clk;

  uart_mem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .clk(clk), .rst(rst),
    .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte),
    .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_mem_addr(mem_addr), .o_mem_we(mem_we), .o_mem_wdata(mem_wdata),
    .o_mem_re(mem_re), .i_mem_rdata(mem_rdata),
    .o_last_addr(last_addr), .o_drop(drop)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // ---------------- environment: RAM, TX serialiser, monitors
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [15:0]       ram [0:(1<<ADDR_W)-1];
  byte unsigned      tx_log[$];
  int                tx_cyc[$];
  int                we_cnt = 0, re_cnt = 0, drop_cnt = 0, we_cyc = 0, re_cyc = 0;
  logic [ADDR_W-1:0] we_addr, re_addr, rd_addr;
  logic [15:0]       we_data;
  logic              launch = 0, rd_pend = 0, outstanding = 0, hold_ok = 0;
  logic [7:0]        held;
  int                tx_left = 0;

  always @(negedge clk) begin
    if (tx_done) outstanding = 1'b0;
    if (rst) hold_ok = 1'b0;
    else begin
      if (mem_we) begin
        we_cnt++; we_cyc = cyc; we_addr = mem_addr; we_data = mem_wdata;
        ram[mem_addr] = mem_wdata;
      end
      if (mem_re) begin
        re_cnt++; re_cyc = cyc; re_addr = mem_addr; rd_pend = 1'b1; rd_addr = mem_addr;
      end
      if (drop) drop_cnt++;
      if (tx_active && hold_ok) chk("tx_hold", tx_byte, held);
      if (tx_dv) begin
        chk("tx_busy", tx_active, 0);
        chk("tx_order", outstanding, 0);
        outstanding = 1'b1; launch = 1'b1; held = tx_byte; hold_ok = 1'b1;
        tx_log.push_back(tx_byte); tx_cyc.push_back(cyc);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    tx_done = 1'b0;
    if (launch) begin launch = 1'b0; tx_active = 1'b1; tx_left = TX_CLKS; end
    else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin tx_active = 1'b0; tx_done = 1'b1; end
    end
    if (rd_pend) begin rd_pend = 1'b0; mem_rdata = ram[rd_addr]; end
  end

  // ---------------- stimulus helpers (caller is always at posedge+1)
  int last_cyc = 0;

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n > 0) #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b; last_cyc = cyc;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  // ---------------- reference model: RAM contents and last accessed address
  logic [15:0]       ref_mem [int];
  logic [ADDR_W-1:0] ref_last = '0;

  task automatic run_cmd(input byte unsigned q[$], input int gap_max, input bit inject);
    byte unsigned exp[$];
    int a, base, w0, r0, d0, lc, min_lat;
    bit exp_we, exp_re;
    logic [15:0] v;
    exp_we = 0; exp_re = 0; min_lat = 1;
    a = (q.size() >= 3) ? int'({q[1], q[2]}) : 0;
    if (q[0] == 8'h57) begin
      if (a < DEPTH) begin
        ref_mem[a] = {q[3], q[4]}; exp.push_back(8'h4B); exp_we = 1; min_lat = 2;
      end else exp.push_back(8'h21);
    end else if (q[0] == 8'h52) begin
      if (a < DEPTH) begin
        v = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
        exp.push_back(v[15:8]); exp.push_back(v[7:0]); exp_re = 1; min_lat = 3;
      end else exp.push_back(8'h21);
    end else exp.push_back(8'h3F);

    base = tx_log.size(); w0 = we_cnt; r0 = re_cnt; d0 = drop_cnt;
    foreach (q[i]) begin
      send_byte(q[i]);
      if (i < q.size() - 1 && gap_max > 0) idle($urandom_range(0, gap_max));
    end
    lc = last_cyc;
    if (inject) begin
      for (int k = 0; k < 200 && tx_log.size() == base; k++) idle(1);
      send_byte(8'h33);
    end
    for (int k = 0; k < 400; k++) begin
      if (tx_log.size() >= base + exp.size() && !tx_active && !launch) break;
      idle(1);
    end
    idle(4);

    chk("rsp_len", tx_log.size() - base, exp.size());
    foreach (exp[i]) if (base + i < tx_log.size()) chk("rsp_byte", tx_log[base+i], exp[i]);
    chk("we_cnt", we_cnt - w0, exp_we);
    chk("re_cnt", re_cnt - r0, exp_re);
    chk("drop_cnt", drop_cnt - d0, inject);
    if (exp_we) begin
      chk("we_lat", we_cyc - lc, 1);
      chk("we_addr", we_addr, a);
      chk("we_data", we_data, {q[3], q[4]});
      chk("ram", ram[a], {q[3], q[4]});
    end
    if (exp_re) begin
      chk("re_lat", re_cyc - lc, 1);
      chk("re_addr", re_addr, a);
    end
    if (tx_log.size() > base) chk("tx_lat", (tx_cyc[base] - lc) >= min_lat, 1);
    if (exp_we || exp_re) ref_last = ADDR_W'(a);
    chk("last_addr", last_addr, ref_last);
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_tx_dv"}, tx_dv, 0);
    chk({pfx, "_tx_byte"}, tx_byte, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_re"}, mem_re, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
    chk({pfx, "_last_addr"}, last_addr, 0);
    chk({pfx, "_drop"}, drop, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned q[$];
    int base, w0, a, k;
    int wr_list[$];

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // basic write / read
    q = {8'h57, 8'h00, 8'h10, 8'hBE, 8'hEF}; run_cmd(q, 0, 0);
    q = {8'h52, 8'h00, 8'h10};               run_cmd(q, 0, 0);
    // bad command and range boundaries
    q = {8'h5A};                             run_cmd(q, 0, 0);
    q = {8'h52, 8'h7D, 8'h00};               run_cmd(q, 0, 0);
    q = {8'h57, 8'h7C, 8'hFF, 8'h12, 8'h34}; run_cmd(q, 1, 0);
    q = {8'h52, 8'h7C, 8'hFF};               run_cmd(q, 1, 0);
    q = {8'h57, 8'h7D, 8'h00, 8'h55, 8'h66}; run_cmd(q, 0, 0);
    q = {8'h57, 8'h80, 8'h10, 8'h77, 8'h88}; run_cmd(q, 0, 0);
    q = {8'h52, 8'h80, 8'h10};               run_cmd(q, 0, 0);

    // abandoned write: no reply, no strobe, no drop
    base = tx_log.size(); w0 = we_cnt; k = drop_cnt;
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
    idle(TIMEOUT_CLKS + 5);
    chk("to_no_tx", tx_log.size() - base, 0);
    chk("to_no_we", we_cnt - w0, 0);
    chk("to_no_drop", drop_cnt - k, 0);
    q = {8'h52, 8'h00, 8'h01}; run_cmd(q, 0, 0);

    // byte landing on the expiry cycle still counts
    base = tx_log.size(); k = re_cnt;
    send_byte(8'h52); send_byte(8'h00);
    idle(TIMEOUT_CLKS);
    send_byte(8'h10);
    idle(3 * TX_CLKS + 10);
    chk("edge_len", tx_log.size() - base, 2);
    if (tx_log.size() >= base + 2) begin
      chk("edge_dh", tx_log[base], 8'hBE);
      chk("edge_dl", tx_log[base+1], 8'hEF);
    end
    chk("edge_re", re_cnt - k, 1);

    // RX byte while replying is dropped once
    q = {8'h52, 8'h00, 8'h10};               run_cmd(q, 0, 1);
    q = {8'h57, 8'h02, 8'h00, 8'hA5, 8'h5A}; run_cmd(q, 0, 1);

    // reset between DH and DL
    base = tx_log.size();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
    for (int i = 0; i < 100 && tx_log.size() == base; i++) idle(1);
    idle(3);
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    idle(2);
    rst = 1'b0;
    ref_last = '0;
    idle(3 * TX_CLKS);
    chk("rst_len", tx_log.size() - base, 1);
    if (tx_log.size() > base) chk("rst_dh", tx_log[base], 8'hBE);
    q = {8'h52, 8'h00, 8'h10}; run_cmd(q, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      q.delete();
      if (k < 4) begin
        a = (k == 0) ? $urandom_range(0, 65535) : $urandom_range(0, DEPTH - 1);
        if (a < DEPTH) wr_list.push_back(a);
        q.push_back(8'h57); q.push_back(8'(a >> 8)); q.push_back(8'(a));
        q.push_back(8'($urandom)); q.push_back(8'($urandom));
      end else if (k < 8) begin
        a = (wr_list.size() > 0 && k < 7) ? wr_list[$urandom_range(0, wr_list.size() - 1)]
                                          : $urandom_range(0, 65535);
        q.push_back(8'h52); q.push_back(8'(a >> 8)); q.push_back(8'(a));
      end else begin
        do a = $urandom_range(0, 255); while (a == 8'h57 || a == 8'h52);
        q.push_back(8'(a));
      end
      run_cmd(q, 3, (i % 8) == 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
